mul_div_unit: RTL and testbench
===============================

# mul_div_unit

- Iterative multiply/divide unit in the EX stage, directly downstream of the register file.
- Consumes the two register read operands (rs, rt) for MULT/MULTU/DIV/DIVU and produces the HI/LO architectural pair.
- HI/LO are read back by MFHI/MFLO and written by MTHI/MTLO.
- Asserts `busy` while an operation is in flight so the hazard logic can stall the front end.

## Interface

Parameters:
- `ITER_CYCLES`, 32: iterations per iterative operation; fixed at 32 for 32-bit operands.

Ports:
- `clk` input 1: rising-edge clock.
- `reset` input 1: asynchronous, active-low; the unit is in reset while `reset` is 0.
- `start` input 1: begin the operation selected by `op`; sampled on the rising edge.
- `op` input 2: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `rs_data` input 32: operand A (multiplicand or dividend), from register file read port 1.
- `rt_data` input 32: operand B (multiplier or divisor), from register file read port 2.
- `hi_we` input 1: MTHI; writes `wdata` into HI.
- `lo_we` input 1: MTLO; writes `wdata` into LO.
- `wdata` input 32: data for MTHI/MTLO.
- `busy` output 1: operation in flight; the pipeline must stall MFHI/MFLO/MTHI/MTLO and further starts.
- `done` output 1: one-cycle pulse when HI/LO hold a new result.
- `hi` output 32: HI register.
- `lo` output 32: LO register.

## Operation

- FSM has three states: IDLE, RUN, DONE.
- Operand capture, on the accepting edge:
  - latch operands and `op`;
  - for signed ops, convert operands to magnitudes and record the result signs;
  - clear the 5-bit iteration counter.
- IDLE/DONE → RUN when `start`=1. DONE → IDLE otherwise.
- RUN performs one step per cycle:
  - multiply: shift-add, one multiplier bit per cycle;
  - divide: restoring, one quotient bit per cycle;
  - when the counter reaches 31, the edge writes HI/LO and the FSM goes RUN → DONE.
- Multiply results:
  - HI:LO = 64-bit product;
  - signed: negate the 64-bit magnitude product if the operand signs differ.
- Divide results:
  - LO = quotient, truncated toward zero;
  - HI = remainder, with the sign of the dividend.
- Divide boundary cases:
  - divide by zero (both DIV and DIVU): HI = `rs_data`, LO = 32'hFFFFFFFF; still takes full latency.
  - DIV 32'h80000000 / 32'hFFFFFFFF: LO = 32'h80000000, HI = 0.
- `start` while RUN: ignored.
- `hi_we`/`lo_we` in IDLE or DONE: write on the edge.
  - `hi_we`/`lo_we` while RUN: ignored.
  - Same edge as an accepted `start`: `start` wins and the writes are dropped.
- `hi`/`lo` change only on the result edge, an MTHI/MTLO edge, or reset.
  - Intermediate partial products and remainders stay in internal registers.

## Timing

- Reset (`reset`=0, asynchronous): state IDLE; `busy`=0, `done`=0, `hi`=0, `lo`=0; internal counter and operands cleared.
  - Reset mid-RUN aborts the operation; no result is written.
- `start` accepted at edge E0:
  - `busy`=1 from after E0 through the cycle before E32 (32 cycles);
  - HI/LO are updated at E32;
  - `done`=1 for exactly the cycle after E32, with `busy`=0.
- Back-to-back: `start` held during DONE is accepted at E33; `busy` rises again with no idle gap.
- MTHI/MTLO: value visible on `hi`/`lo` the cycle after the write edge.
- `busy` and `done` are registered outputs, decoded from state only.

## Configuration

- Macro: `MUL_DIV_FAST_MUL_EN`.
- When defined:
  - MULT/MULTU use a single-cycle combinational 32×32 multiply of the captured operands;
  - start at E0 → HI/LO written at E1, `busy`=1 only for the cycle between E0 and E1, `done`=1 the cycle after E1;
  - DIV/DIVU are unchanged.
- When undefined: all four ops use the 32-cycle iterative path described above.

## Test plan

- Reset: drive `reset`=0 mid-RUN of MULTU 7×9 → `busy`=0, `done`=0, `hi`=0, `lo`=0 immediately; no `done` pulse follows.
- MULT: `rs`=32'hFFFFFFFD (-3), `rt`=5 → `done` one cycle after E32 with HI=32'hFFFFFFFF, LO=32'hFFFFFFF1.
  - Fast build: same result, `done` one cycle after E1.
- MULTU: 32'hFFFFFFFF × 32'hFFFFFFFF → HI=32'hFFFFFFFE, LO=32'h00000001.
- DIV: -7 / 2 → LO=32'hFFFFFFFD, HI=32'hFFFFFFFF.
  - DIVU 100 / 0 → HI=100, LO=32'hFFFFFFFF.
  - DIV 32'h80000000 / -1 → LO=32'h80000000, HI=0.
- Hazards, part 1: with `hi`=0x11, pulse `hi_we` with `wdata`=0x55 during RUN → `hi` unchanged until the result edge.
  - Pulse `start` during RUN → ignored; exactly one `done` pulse.
- Hazards, part 2: `start` together with `lo_we` in IDLE → `lo` not written by MTLO; operation proceeds.
  - `start` held through DONE → second op begins at E33 with `busy` continuous.

Source files
------------

// File: rtl/mul_div_unit_if.sv
// Pipeline-facing bundle of the multiply/divide unit: operation request,
// MTHI/MTLO writes, the HI/LO architectural pair and the busy/done status.
interface mul_div_unit_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, rs_data, rt_data, hi_we, lo_we, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, rs_data, rt_data, hi_we, lo_we, wdata,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit producing HI/LO (shift-add multiply, restoring divide).
// Define MUL_DIV_FAST_MUL_EN to finish MULT/MULTU in one RUN cycle with a combinational multiplier.
module mul_div_unit #(
    parameter int ITER_CYCLES = 32
) (
    input  logic          clk,
    input  logic          reset,
    mul_div_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    localparam logic [4:0] LAST_ITER = 5'(ITER_CYCLES - 1);

    state_e      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [63:0] acc_q, acc_d;    // mul: {partial product, multiplier}; div: {remainder, dividend/quotient}
    logic [31:0] opb_q, opb_d;    // multiplicand or divisor magnitude
    logic        neg_res_q, neg_res_d;
    logic        neg_rem_q, neg_rem_d;
    logic        div_zero_q, div_zero_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        is_signed;
    logic        accept;
    logic        last_step;
    logic [31:0] a_mag, b_mag;
    logic [32:0] mul_sum;
    logic [63:0] mul_step;
    logic [32:0] rem_shift, rem_diff;
    logic [63:0] div_step;
    logic [63:0] prod, prod_signed;
    logic [31:0] quo, rem;

    always_comb begin
        is_signed = ~bus.op[0];
        a_mag     = (is_signed && bus.rs_data[31]) ? -bus.rs_data : bus.rs_data;
        b_mag     = (is_signed && bus.rt_data[31]) ? -bus.rt_data : bus.rt_data;
        accept    = bus.start && (state_q != RUN);

        mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
        mul_step = {mul_sum, acc_q[31:1]};

        // A borrow out of bit 32 means the trial subtraction failed and the remainder is restored.
        rem_shift = {acc_q[63:32], acc_q[31]};
        rem_diff  = rem_shift - {1'b0, opb_q};
        if (!rem_diff[32]) begin
            div_step = {rem_diff[31:0], acc_q[30:0], 1'b1};
        end else begin
            div_step = {rem_shift[31:0], acc_q[30:0], 1'b0};
        end

`ifdef MUL_DIV_FAST_MUL_EN
        last_step = (cnt_q == LAST_ITER) || !op_q[1];
        prod      = 64'(opb_q) * 64'(acc_q[31:0]);
`else
        last_step = (cnt_q == LAST_ITER);
        prod      = mul_step;
`endif
        prod_signed = neg_res_q ? -prod : prod;
        quo = div_zero_q ? 32'hFFFF_FFFF : (neg_res_q ? -div_step[31:0] : div_step[31:0]);
        rem = neg_rem_q ? -div_step[63:32] : div_step[63:32];
    end

    // NOTE: all next-state values are computed here with blocking assignments and a
    // default of "hold"; the single always_ff below only copies _d into _q.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        acc_d      = acc_q;
        opb_d      = opb_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        div_zero_d = div_zero_q;
        cnt_d      = cnt_q;
        hi_d       = hi_q;
        lo_d       = lo_q;

        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    state_d    = RUN;
                    op_d       = bus.op;
                    neg_res_d  = is_signed && (bus.rs_data[31] ^ bus.rt_data[31]);
                    neg_rem_d  = is_signed && bus.rs_data[31];
                    div_zero_d = (bus.rt_data == 32'd0);
                    cnt_d      = 5'd0;
                    if (bus.op[1]) begin
                        acc_d = {32'd0, a_mag};
                        opb_d = b_mag;
                    end else begin
                        acc_d = {32'd0, b_mag};
                        opb_d = a_mag;
                    end
                end else begin
                    state_d = IDLE;
                    if (bus.hi_we) hi_d = bus.wdata;
                    if (bus.lo_we) lo_d = bus.wdata;
                end
            end
            RUN: begin
                acc_d = op_q[1] ? div_step : mul_step;
                cnt_d = cnt_q + 5'd1;
                if (last_step) begin
                    state_d = DONE;
                    if (op_q[1]) begin
                        hi_d = rem;
                        lo_d = quo;
                    end else begin
                        hi_d = prod_signed[63:32];
                        lo_d = prod_signed[31:0];
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    // NOTE: every flop, datapath included, is cleared by the asynchronous reset so an
    // aborted operation leaves no stale operands or partial results behind.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            op_q       <= 2'd0;
            acc_q      <= 64'd0;
            opb_q      <= 32'd0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            cnt_q      <= 5'd0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            acc_q      <= acc_d;
            opb_q      <= opb_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            div_zero_q <= div_zero_d;
            cnt_q      <= cnt_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: stimulus pushes expected HI/LO, a monitor pops on done.
// Honours MUL_DIV_FAST_MUL_EN for the expected multiply latency.
module tb_mul_div_unit;
    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        string       name;
    } exp_t;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;
    int   done_cnt;
    exp_t exp_q[$];
    exp_t mon_e;

    mul_div_unit_if bus();

    mul_div_unit #(.ITER_CYCLES(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic on the architectural rules.
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'b00: p = 64'(sa * sb);
            2'b01: p = 64'(a) * 64'(b);
            default: begin
                if (b == 32'd0) begin
                    p = {a, 32'hFFFF_FFFF};
                end else if (op == 2'b10) begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end else begin
                    p = {a % b, a / b};
                end
            end
        endcase
        return p;
    endfunction

    function automatic int lat_of(input logic [1:0] op);
`ifdef MUL_DIV_FAST_MUL_EN
        return op[1] ? 32 : 1;
`else
        return 32;
`endif
    endfunction

    always @(negedge clk) begin
        if (reset && bus.done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL spurious_done: got a done pulse, expected none pending");
            end else begin
                mon_e = exp_q.pop_front();
                check({mon_e.name, "_hi"}, 64'(bus.hi), 64'(mon_e.hi));
                check({mon_e.name, "_lo"}, 64'(bus.lo), 64'(mon_e.lo));
            end
        end
    end

    // Issues a start at the next edge and returns at the negedge after it, start dropped.
    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [63:0] exp, input string name);
        @(negedge clk);
        bus.start   = 1'b1;
        bus.op      = op;
        bus.rs_data = a;
        bus.rt_data = b;
        exp_q.push_back('{hi: exp[63:32], lo: exp[31:0], name: name});
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Called at the first..n-th negedge after the accepting edge; checks latency and in-flight behaviour.
    task automatic wait_done(input int lat, input string name, input int first);
        int          cycles;
        bit          busy_ok;
        bit          stable_ok;
        logic [31:0] h0, l0;
        cycles    = first;
        busy_ok   = 1'b1;
        stable_ok = 1'b1;
        h0        = bus.hi;
        l0        = bus.lo;
        while (!bus.done && cycles < 200) begin
            if (!bus.busy) busy_ok = 1'b0;
            if (bus.hi !== h0 || bus.lo !== l0) stable_ok = 1'b0;
            @(negedge clk);
            cycles++;
        end
        check({name, "_latency"}, 64'(cycles), 64'(lat + 1));
        check({name, "_busy_in_flight"}, 64'(busy_ok), 64'd1);
        check({name, "_hilo_stable"}, 64'(stable_ok), 64'd1);
        check({name, "_busy_at_done"}, 64'(bus.busy), 64'd0);
        @(negedge clk);
        check({name, "_done_one_cycle"}, 64'(bus.done), 64'd0);
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input string name);
        start_op(op, a, b, exp, name);
        wait_done(lat_of(op), name, 1);
    endtask

    task automatic mt_write(input bit to_hi, input logic [31:0] val, input string name);
        @(negedge clk);
        bus.hi_we = to_hi;
        bus.lo_we = !to_hi;
        bus.wdata = val;
        @(negedge clk);
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        check(name, 64'(to_hi ? bus.hi : bus.lo), 64'(val));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no end of test, expected finish before 1 ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0]  op;
        logic [31:0] a, b, lo_before;
        int          done_before;
        int          mid;

        vectors     = 0;
        miscompares = 0;
        done_cnt    = 0;
        reset       = 1'b0;
        bus.start   = 1'b0;
        bus.op      = 2'b00;
        bus.rs_data = 32'd0;
        bus.rt_data = 32'd0;
        bus.hi_we   = 1'b0;
        bus.lo_we   = 1'b0;
        bus.wdata   = 32'd0;

        #1;
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_done", 64'(bus.done), 64'd0);
        check("reset_hi", 64'(bus.hi), 64'd0);
        check("reset_lo", 64'(bus.lo), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        run_op(2'b00, 32'hFFFF_FFFD, 32'd5,        {32'hFFFF_FFFF, 32'hFFFF_FFF1}, "mult_neg3x5");
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'h0000_0001}, "multu_max");
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2,        {32'hFFFF_FFFF, 32'hFFFF_FFFD}, "div_neg7by2");
        run_op(2'b11, 32'd100,       32'd0,        {32'd100,       32'hFFFF_FFFF}, "divu_by_zero");
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0,        32'h8000_0000}, "div_overflow");

        // MTHI during RUN and a second start are both ignored.
        mt_write(1'b1, 32'h11, "mthi_idle");
        start_op(2'b11, 32'd500, 32'd9, model(2'b11, 32'd500, 32'd9), "haz1");
        done_before = done_cnt;
        bus.hi_we   = 1'b1;
        bus.wdata   = 32'h55;
        bus.start   = 1'b1;
        bus.op      = 2'b01;
        bus.rs_data = 32'd3;
        bus.rt_data = 32'd4;
        @(negedge clk);
        bus.hi_we = 1'b0;
        bus.start = 1'b0;
        check("haz1_hi_hold", 64'(bus.hi), 64'h11);
        wait_done(32, "haz1", 2);
        repeat (5) @(negedge clk);
        check("haz1_single_done", 64'(done_cnt - done_before), 64'd1);

        // start wins over a simultaneous MTLO.
        mt_write(1'b0, 32'h1234, "mtlo_idle");
        lo_before = bus.lo;
        @(negedge clk);
        bus.start   = 1'b1;
        bus.op      = 2'b01;
        bus.rs_data = 32'd7;
        bus.rt_data = 32'd6;
        bus.lo_we   = 1'b1;
        bus.wdata   = 32'hDEAD_BEEF;
        exp_q.push_back('{hi: 32'd0, lo: 32'd42, name: "haz2"});
        @(negedge clk);
        bus.start = 1'b0;
        bus.lo_we = 1'b0;
        check("haz2_lo_not_written", 64'(bus.lo), 64'(lo_before));
        wait_done(lat_of(2'b01), "haz2", 1);

        // Back-to-back: start held through DONE.
        start_op(2'b11, 32'd1000, 32'd7, model(2'b11, 32'd1000, 32'd7), "b2b_a");
        bus.start   = 1'b1;
        bus.op      = 2'b10;
        bus.rs_data = 32'hFFFF_FFCE;
        bus.rt_data = 32'd3;
        exp_q.push_back('{hi: 32'hFFFF_FFFE, lo: 32'hFFFF_FFF0, name: "b2b_b"});
        wait_done(32, "b2b_a", 1);
        check("b2b_busy_continuous", 64'(bus.busy), 64'd1);
        bus.start = 1'b0;
        wait_done(32, "b2b_b", 1);

        // Reset mid-RUN of MULTU 7x9 aborts with no result.
        mid = (lat_of(2'b01) > 1) ? 10 : 0;
        start_op(2'b01, 32'd7, 32'd9, 64'd63, "rst_abort");
        repeat (mid) @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_done", 64'(bus.done), 64'd0);
        check("abort_hi", 64'(bus.hi), 64'd0);
        check("abort_lo", 64'(bus.lo), 64'd0);
        exp_q.delete();
        done_before = done_cnt;
        @(negedge clk);
        reset = 1'b1;
        repeat (40) @(negedge clk);
        check("abort_no_done", 64'(done_cnt - done_before), 64'd0);

        for (int i = 0; i < 30; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 9))
                0: b = 32'd0;
                1: b = 32'hFFFF_FFFF;
                2: b = 32'($urandom_range(1, 15));
                3: a = 32'h8000_0000;
                default: ;
            endcase
            run_op(op, a, b, model(op, a, b), $sformatf("rand%0d_op%0d", i, op));
            if ($urandom_range(0, 3) == 0) begin
                mt_write(1'($urandom_range(0, 1)), $urandom, $sformatf("rand%0d_mt", i));
            end
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
